// File: rtl/led_anim_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : led_anim_scheduler
//  Purpose  : Shares a 5-LED bar between NUM_REQ animation requesters.
//             Request pulses are latched as pending bits. One request is
//             granted at a time, lowest index first, and the granted
//             requester's pattern plays at a slow tick rate.
//  Ports    : clk     - system clock
//             reset   - asynchronous, active-high reset
//             req     - request pulses/levels, bit 0 = highest priority
//             led     - LED bar drive
//             busy    - high while an animation is armed or running
//             grant   - one-hot, 1-cycle pulse when a request is accepted
//             cur_id  - index of the granted/running requester
//             done    - 1-cycle pulse when an animation completes normally
//  Config   : LED_SCHED_PREEMPT_EN - when defined, a pending higher-priority
//             request aborts the armed/running animation
//  Revision : 1.0 - initial release
// ============================================================================
module led_anim_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int TICK_DIV = 8388608,
  parameter int STEPS    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [4:0]         led,
  output logic               busy,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         cur_id,
  output logic               done
);

  localparam int                DIV_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int                STEP_W     = 4;
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(STEPS - 2);
  localparam logic [STEP_W-1:0] STEP_FINAL = STEP_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    div;
  logic                tick;
  logic [NUM_REQ-1:0]  pending, pending_nxt;
  logic [NUM_REQ-1:0]  grant_nxt, grant_clr;
  logic [STEP_W-1:0]   step, step_nxt;
  logic [4:0]          led_nxt;
  logic [2:0]          cur_id_nxt;
  logic                done_nxt;
  logic [2:0]          lowest_id;
  logic                preempt;

  // Pattern value for requester id at animation step s (s = 0..STEPS-2).
  function automatic logic [4:0] pattern(input logic [2:0] id, input logic [STEP_W-1:0] s);
    logic [4:0] p;
    p = 5'b00000;
    case (id[1:0])
      2'd0:    p = (s >= 4'd4) ? 5'b11111 : ((5'd2 << s[1:0]) - 5'd1);
      2'd1:    p = s[0] ? 5'b00000 : 5'b11111;
      2'd2:    p = 5'd1 << (s % 4'd5);
      default: p = 5'b11111 >> s;  // shifts to zero naturally for s >= 5
    endcase
    return p;
  endfunction

  // Free-running tick divider.
  assign tick = (div == DIV_LAST);

  // Lowest set pending index wins; scan from the top so the lowest overwrites.
  always_comb begin
    lowest_id = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending[i]) lowest_id = 3'(i);
    end
  end

`ifdef LED_SCHED_PREEMPT_EN
  // Any pending requester with a smaller index than the active one aborts it.
  logic [NUM_REQ-1:0] higher_mask;
  always_comb begin
    higher_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      higher_mask[i] = (3'(i) < cur_id);
    end
  end
  assign preempt = |(pending & higher_mask);
`else
  assign preempt = 1'b0;
`endif

  assign busy = (state != S_IDLE);

  always_comb begin
    state_nxt  = state;
    step_nxt   = step;
    led_nxt    = led;
    cur_id_nxt = cur_id;
    grant_nxt  = '0;
    grant_clr  = '0;
    done_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        if (|pending) begin
          cur_id_nxt = lowest_id;
          grant_clr  = NUM_REQ'(1) << lowest_id;
          grant_nxt  = grant_clr;
          state_nxt  = S_ARM;
        end
      end
      S_ARM: begin
        led_nxt = 5'b00000;
        if (preempt) begin
          step_nxt  = '0;
          state_nxt = S_IDLE;
        end else if (tick) begin
          step_nxt  = '0;
          led_nxt   = pattern(cur_id, '0);
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (preempt) begin
          led_nxt   = 5'b00000;
          step_nxt  = '0;
          state_nxt = S_IDLE;
        end else if (tick) begin
          if (step == STEP_LAST) begin
            // The final step always blanks the bar and reports completion.
            led_nxt   = 5'b00000;
            step_nxt  = STEP_FINAL;
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            step_nxt = step + 4'd1;
            led_nxt  = pattern(cur_id, step + 4'd1);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // A new request in the same cycle as its grant stays pending.
    pending_nxt = (pending & ~grant_clr) | req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      div     <= '0;
      pending <= '0;
      step    <= '0;
      led     <= 5'b00000;
      grant   <= '0;
      cur_id  <= 3'd0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      div     <= tick ? '0 : div + 1'b1;
      pending <= pending_nxt;
      step    <= step_nxt;
      led     <= led_nxt;
      grant   <= grant_nxt;
      cur_id  <= cur_id_nxt;
      done    <= done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_anim_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_anim_scheduler
//  Purpose  : Self-checking bench for led_anim_scheduler. A frame-queue model
//             predicts every output each cycle; directed scenarios add
//             hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_anim_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int TICK_DIV = 4;
  localparam int STEPS    = 6;

  localparam logic [4:0] FILL_T  [0:4] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
  localparam logic [4:0] CHASE_T [0:4] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
  localparam logic [4:0] DRAIN_T [0:4] = '{5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001};

  logic               clk   = 1'b0;
  logic               reset = 1'b1;
  logic [NUM_REQ-1:0] req   = '0;
  logic [4:0]         led;
  logic               busy;
  logic [NUM_REQ-1:0] grant;
  logic [2:0]         cur_id;
  logic               done;

  led_anim_scheduler #(
    .NUM_REQ (NUM_REQ),
    .TICK_DIV(TICK_DIV),
    .STEPS   (STEPS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .led   (led),
    .busy  (busy),
    .grant (grant),
    .cur_id(cur_id),
    .done  (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;
  int gcnt   = 0;
  int dcnt   = 0;
  int m_gcnt = 0;

  // Hand-written expected LED sequences (five pattern steps then blank).
  logic [4:0] seq_fill  [0:5] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b00000};
  logic [4:0] seq_blink [0:5] = '{5'b11111, 5'b00000, 5'b11111, 5'b00000, 5'b11111, 5'b00000};
  logic [4:0] seq_chase [0:5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00000};
  logic [4:0] seq_drain [0:5] = '{5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000};

  // ---------------- behavioural model ----------------
  logic [4:0]         m_led   = '0;
  logic               m_busy  = 1'b0;
  logic [NUM_REQ-1:0] m_grant = '0;
  logic [2:0]         m_cur   = '0;
  logic               m_done  = 1'b0;
  logic [NUM_REQ-1:0] m_pend  = '0;
  logic [4:0]         frames[$];
  int                 nedge   = 0;

  function automatic logic [4:0] pat_model(input int id, input int s);
    case (id % 4)
      0:       return FILL_T[(s > 4) ? 4 : s];
      1:       return (s % 2 == 0) ? 5'b11111 : 5'b00000;
      2:       return CHASE_T[s % 5];
      default: return (s >= 5) ? 5'b00000 : DRAIN_T[s];
    endcase
  endfunction

  // Once granted, an animation is a list of frames: one per tick, the last
  // being the blank frame that signals completion.
  task automatic model_step();
    logic [NUM_REQ-1:0] oldp;
    logic               tk;
    int                 id;
    oldp = m_pend;
    tk   = ((nedge % TICK_DIV) == TICK_DIV - 1);
    if (reset) begin
      m_pend = '0; m_led = '0; m_busy = 1'b0; m_grant = '0;
      m_cur = '0; m_done = 1'b0; nedge = 0;
      frames.delete();
    end else begin
      nedge++;
      m_grant = '0;
      m_done  = 1'b0;
      if (!m_busy) begin
        if (oldp != '0) begin
          id = 0;
          while (!oldp[id]) id++;
          m_cur      = 3'(id);
          m_grant    = NUM_REQ'(1 << id);
          m_pend[id] = 1'b0;
          m_busy     = 1'b1;
          m_gcnt++;
          frames.delete();
          for (int s = 0; s <= STEPS - 2; s++) frames.push_back(pat_model(id, s));
          frames.push_back(5'b00000);
        end
      end
`ifdef LED_SCHED_PREEMPT_EN
      else if ((oldp & ((NUM_REQ'(1) << m_cur) - NUM_REQ'(1))) != '0) begin
        m_led  = 5'b00000;
        m_busy = 1'b0;
        frames.delete();
      end
`endif
      else if (tk) begin
        m_led = frames.pop_front();
        if (frames.size() == 0) begin
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end
      m_pend = m_pend | req;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (grant != '0) gcnt++;
    if (done) dcnt++;
    if (cmp_en) begin
      checks++;
      if ({led, busy, grant, cur_id, done} === {m_led, m_busy, m_grant, m_cur, m_done})
        passes++;
      else
        $display("FAIL cycle_cmp t=%0t actual led=%b busy=%b grant=%b cur_id=%0d done=%b required led=%b busy=%b grant=%b cur_id=%0d done=%b",
                 $time, led, busy, grant, cur_id, done, m_led, m_busy, m_grant, m_cur, m_done);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Bounded wait for the LED bar to show a value.
  task automatic wait_led(input string name, input logic [4:0] v);
    int n;
    n = 0;
    while (led !== v && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(led), 32'(v));
  endtask

  // Pulse req for one sampling edge; returns 2 time units after that edge.
  task automatic pulse(input logic [NUM_REQ-1:0] v);
    @(posedge clk); #2 req = v;
    @(posedge clk); #2 req = '0;
  endtask

  task automatic wait_grant(input string name, input logic [NUM_REQ-1:0] v);
    int n;
    n = 0;
    while (grant === '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(grant), 32'(v));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    cmp_en = 1'b1;

    // Quiet period.
    repeat (50) @(negedge clk);
    chk("idle_led", 32'(led), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_gcnt", 32'(gcnt), 32'd0);

    // Single highest-priority request: fill pattern.
    pulse(4'b0001);
    chk("grant_latency_pre", 32'(grant), 32'd0);
    @(posedge clk); #2;
    chk("grant_id0", 32'(grant), 32'b0001);
    chk("busy_arm", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) wait_led("fill_seq", seq_fill[i]);
    chk("fill_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("busy_after_fill", 32'(busy), 32'd0);

    // Two simultaneous requests: id1 blinks first, then id2 chases.
    pulse(4'b0110);
    @(posedge clk); #2;
    chk("grant_id1", 32'(grant), 32'b0010);
    for (int i = 0; i < 6; i++) wait_led("blink_seq", seq_blink[i]);
    chk("blink_done", 32'(done), 32'd1);
    @(negedge clk);
    wait_grant("grant_id2", 4'b0100);
    for (int i = 0; i < 6; i++) wait_led("chase_seq", seq_chase[i]);
    chk("chase_done", 32'(done), 32'd1);

    // Lowest-priority requester: drain pattern.
    repeat (3) @(negedge clk);
    pulse(4'b1000);
    @(posedge clk); #2;
    chk("grant_id3", 32'(grant), 32'b1000);
    for (int i = 0; i < 6; i++) wait_led("drain_seq", seq_drain[i]);
    chk("drain_done", 32'(done), 32'd1);

    // Higher-priority request while id2 is mid-run (abort or queue).
    repeat (3) @(negedge clk);
    pulse(4'b0100);
    wait_led("chase_step2", 5'b00100);
    pulse(4'b0001);
    repeat (80) @(negedge clk);
    chk("busy_after_preempt_case", 32'(busy), 32'd0);

    // Reset in the middle of an id1 run with id3 queued.
    pulse(4'b0010);
    wait_led("blink_first", 5'b11111);
    pulse(4'b1000);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("reset_led_clear", 32'(led), 32'd0);
    chk("reset_busy_clear", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    gcnt = 0;
    dcnt = 0;
    repeat (40) @(negedge clk);
    chk("no_grant_after_reset", 32'(gcnt), 32'd0);
    chk("no_done_after_reset", 32'(dcnt), 32'd0);

    // Level request held: back-to-back id1 animations.
    gcnt = 0;
    m_gcnt = 0;
    @(posedge clk); #2 req = 4'b0010;
    repeat (100) @(posedge clk);
    #2 req = '0;
    repeat (60) @(negedge clk);
    chk("held_grant_count_model", 32'(gcnt), 32'(m_gcnt));
    chk("held_grant_count_min", 32'(gcnt >= 4), 32'd1);
    chk("held_busy_end", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
